lsu_bus_adapter: RTL and testbench

- Load/store unit sitting directly downstream of the core's memory stage; replaces the fixed-latency data memory port with a variable-latency request/grant/response data bus.
- Takes the M-stage memory operation: address, store data, funct3 size/sign code, read/write.
- Generates word-aligned bus accesses with byte enables and extracts/sign-extends load data.
- Holds the pipeline stalled until the access completes, faults or times out.

---
 rtl/lsu_bus_adapter.sv | 246 ++++++++++++++++++++++++
 tb/tb_lsu_bus_adapter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_adapter.sv
// +--------------------------------------------------------------------------+
// | lsu_bus_adapter: M-stage load/store to request/grant/response data bus   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu_bus_adapter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int unsigned         c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  localparam logic [1:0] c_flt_ok    = 2'b00;
  localparam logic [1:0] c_flt_align = 2'b01;
  localparam logic [1:0] c_flt_bus   = 2'b10;
  localparam logic [1:0] c_flt_size  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic [3:0]           bus_be_q, bus_be_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic [1:0]           rsp_fault_q, rsp_fault_d;

  logic                 w_illegal;
  logic                 w_misaligned;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;

  // Request decode from the live M-stage fields, used only in IDLE.
  always_comb begin
    w_illegal = 1'b0;
    if (req_we) begin
      w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
        default:                                w_illegal = 1'b1;
      endcase
    end
    w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    w_be    = 4'b1111;
    w_wdata = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {req_addr[1], 1'b0};
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  // Load lane extraction driven by the latched size and low address bits.
  always_comb begin
    case (addr_lo_q)
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      2'd3:    w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          if (w_illegal) begin
            state_d     = DONE;
            rsp_fault_d = c_flt_size;
            rsp_rdata_d = 32'd0;
          end else if (w_misaligned) begin
            state_d     = DONE;
            rsp_fault_d = c_flt_align;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_be_d    = w_be;
            bus_wdata_d = w_wdata;
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          if (we_q) begin
            state_d     = DONE;
            rsp_fault_d = c_flt_ok;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d = WAIT;
          end
        end else if (cnt_q == c_cnt_last) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          rsp_fault_d = c_flt_bus;
          rsp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        // A response in the expiry cycle still counts as a completion.
        if (bus_rvalid) begin
          state_d     = DONE;
          rsp_fault_d = bus_err ? c_flt_bus : c_flt_ok;
          rsp_rdata_d = bus_err ? 32'd0 : w_load;
        end else if (cnt_q == c_cnt_last) begin
          state_d     = DONE;
          rsp_fault_d = c_flt_bus;
          rsp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_fault_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign stall     = req_valid && (state_q != DONE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_adapter.sv
// +--------------------------------------------------------------------------+
// | tb_lsu_bus_adapter: scoreboard bench for lsu_bus_adapter                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_bus_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  lsu_bus_adapter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_data;
    logic [1:0]  fault;
    int          stall;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int total = 0;
  int bad   = 0;

  // Bus responder configuration, written by the stimulus process.
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic [31:0] rd_data   = 32'd0;
  logic        rd_err    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave model: grants after gnt_delay REQ cycles, answers loads rv_delay cycles later.
  initial begin
    int req_cycles = 0;
    int rd_wait = 0;
    logic rd_pending = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
      if (!rst_n) begin
        req_cycles = 0;
        rd_pending = 1'b0;
      end else begin
        if (rd_pending) begin
          if (rd_wait == rv_delay) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rd_data;
            bus_err    = rd_err;
            rd_pending = 1'b0;
          end else begin
            rd_wait++;
          end
        end
        if (bus_req) begin
          if (req_cycles == gnt_delay) begin
            bus_gnt    = 1'b1;
            req_cycles = 0;
            if (!bus_we) begin
              rd_pending = 1'b1;
              rd_wait    = 0;
            end
          end else begin
            req_cycles++;
          end
        end else begin
          req_cycles = 0;
        end
      end
    end
  end

  // Monitor: response scoreboard, bus transaction scoreboard, bus stability.
  initial begin
    int          stall_cnt = 0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
    logic [3:0]  prev_be = 4'd0;
    rsp_t        er;
    bus_t        eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
        prev_req  = 1'b0;
        prev_gnt  = 1'b0;
      end else begin
        if (stall) stall_cnt++;
        if (rsp_valid) begin
          if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
          end else begin
            er = rsp_q.pop_front();
            if (er.chk_data) chk("rsp_rdata", rsp_rdata, er.rdata);
            chk("rsp_fault", {30'd0, rsp_fault}, {30'd0, er.fault});
            chk("stall_cycles", stall_cnt, er.stall);
          end
          stall_cnt = 0;
        end
        if (prev_req && !prev_gnt && bus_req) begin
          chk("bus_hold_addr",  bus_addr,  prev_addr);
          chk("bus_hold_be",    {28'd0, bus_be}, {28'd0, prev_be});
          chk("bus_hold_wdata", bus_wdata, prev_wdata);
          chk("bus_hold_we",    {31'd0, bus_we}, {31'd0, prev_we});
        end
        if (prev_req && prev_gnt) chk("bus_req_drop", {31'd0, bus_req}, 32'd0);
        if (bus_req && bus_gnt) begin
          if (bus_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_bus: got access addr=%h expected none", bus_addr);
          end else begin
            eb = bus_q.pop_front();
            chk("bus_we",   {31'd0, bus_we}, {31'd0, eb.we});
            chk("bus_addr", bus_addr, eb.addr);
            chk("bus_be",   {28'd0, bus_be}, {28'd0, eb.be});
            if (eb.we) chk("bus_wdata", bus_wdata, eb.wdata);
          end
        end
        prev_req = bus_req; prev_gnt = bus_gnt; prev_we = bus_we;
        prev_addr = bus_addr; prev_be = bus_be; prev_wdata = bus_wdata;
      end
    end
  end

  task automatic wait_rsp(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] e_rdata, input logic [1:0] e_fault, input int e_stall,
                       input logic e_bus, input logic [3:0] e_be, input logic [31:0] e_bwdata);
    rsp_t r;
    bus_t b;
    r.rdata = e_rdata; r.chk_data = !we; r.fault = e_fault; r.stall = e_stall;
    rsp_q.push_back(r);
    if (e_bus) begin
      b.we = we; b.addr = {addr[31:2], 2'b00}; b.be = e_be; b.wdata = e_bwdata;
      bus_q.push_back(b);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    wait_rsp(name);
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t b;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_bus_req",   {31'd0, bus_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_bus_addr",  bus_addr, 32'd0);
    chk("rst_stall",     {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // LB sign-extended from byte 3, zero-wait bus.
    rd_data = 32'h80FF_1234; rd_err = 1'b0; gnt_delay = 0; rv_delay = 0;
    issue("lb", 1'b0, 3'b000, 32'h103, 32'd0, 32'hFFFF_FF80, 2'b00, 3, 1'b1, 4'b1111, 32'd0);
    idle_cycle();

    // SH to upper half with grant delayed two cycles.
    gnt_delay = 2;
    issue("sh", 1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 32'd0, 2'b00, 4, 1'b1, 4'b1100, 32'hABCD_ABCD);
    gnt_delay = 0;
    idle_cycle();

    issue("lw_mis", 1'b0, 3'b010, 32'h41, 32'd0, 32'd0, 2'b01, 1, 1'b0, 4'd0, 32'd0);
    chk("lw_mis_no_req", {31'd0, bus_req}, 32'd0);
    idle_cycle();
    issue("ld_ill", 1'b0, 3'b011, 32'h40, 32'd0, 32'd0, 2'b11, 1, 1'b0, 4'd0, 32'd0);
    idle_cycle();
    issue("st_ill", 1'b1, 3'b100, 32'h40, 32'd0, 32'd0, 2'b11, 1, 1'b0, 4'd0, 32'd0);
    idle_cycle();
    issue("sh_mis", 1'b1, 3'b001, 32'h43, 32'd0, 32'd0, 2'b01, 1, 1'b0, 4'd0, 32'd0);
    idle_cycle();

    rd_data = 32'h80FF_1234;
    issue("lh", 1'b0, 3'b001, 32'h102, 32'd0, 32'hFFFF_80FF, 2'b00, 3, 1'b1, 4'b1111, 32'd0);
    idle_cycle();
    issue("lhu", 1'b0, 3'b101, 32'h100, 32'd0, 32'h0000_1234, 2'b00, 3, 1'b1, 4'b1111, 32'd0);
    idle_cycle();
    issue("sb", 1'b1, 3'b000, 32'h101, 32'h0000_0055, 32'd0, 2'b00, 2, 1'b1, 4'b0010, 32'h5555_5555);
    idle_cycle();

    rd_data = 32'h1234_5678; rd_err = 1'b1;
    issue("lw_err", 1'b0, 3'b010, 32'h500, 32'd0, 32'd0, 2'b10, 3, 1'b1, 4'b1111, 32'd0);
    rd_err = 1'b0;
    idle_cycle();

    // Load granted but answered only long after the timeout fires.
    rv_delay = 30; rd_data = 32'h1111_2222;
    issue("ld_tmo", 1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 2'b10, 17, 1'b1, 4'b1111, 32'd0);
    req_valid = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #2;
      chk("late_rvalid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rv_delay = 0;

    // Store that is never granted.
    gnt_delay = 100;
    issue("st_tmo", 1'b1, 3'b010, 32'h400, 32'h0BAD_F00D, 32'd0, 2'b10, 17, 1'b0, 4'd0, 32'd0);
    chk("st_tmo_req_low", {31'd0, bus_req}, 32'd0);
    gnt_delay = 0;
    idle_cycle();

    // Back-to-back: second request presented during DONE with req_valid held.
    rd_data = 32'h1234_56F0;
    issue("lbu_b2b", 1'b0, 3'b100, 32'h200, 32'd0, 32'h0000_00F0, 2'b00, 3, 1'b1, 4'b1111, 32'd0);
    issue("sw_b2b", 1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 32'd0, 2'b00, 2, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    idle_cycle();

    // Reset asserted while the load sits in WAIT.
    rv_delay = 50;
    b.we = 1'b0; b.addr = 32'h700; b.be = 4'b1111; b.wdata = 32'd0;
    bus_q.push_back(b);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
    repeat (4) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("arst_bus_req",   {31'd0, bus_req}, 32'd0);
    chk("arst_bus_addr",  bus_addr, 32'd0);
    chk("arst_bus_be",    {28'd0, bus_be}, 32'd0);
    chk("arst_bus_we",    {31'd0, bus_we}, 32'd0);
    chk("arst_bus_wdata", bus_wdata, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    chk("arst_rsp_fault", {30'd0, rsp_fault}, 32'd0);
    rv_delay = 0; rd_data = 32'hCAFE_F00D;
    @(posedge clk); #2;
    @(posedge clk); #2;
    req_addr = 32'h600;
    begin
      rsp_t r;
      r.rdata = 32'hCAFE_F00D; r.chk_data = 1'b1; r.fault = 2'b00; r.stall = 3;
      rsp_q.push_back(r);
      b.addr = 32'h600;
      bus_q.push_back(b);
    end
    rst_n = 1'b1;
    wait_rsp("post_rst");
    idle_cycle();

    repeat (3) begin @(posedge clk); #2; end
    chk("rsp_q_empty", rsp_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
